// File: rtl/cnn_pkg.sv
// Purpose: shared CNN definitions (scheduler state encoding, cycles-per-pixel derivation).
// Used by the conv kernel scheduler and the pooling stage.
package cnn_pkg;

    typedef enum logic {
        SCH_IDLE  = 1'b0,
        SCH_ISSUE = 1'b1
    } sched_state_t;

    // Cycles a pixel is held so every kernel group sees it once.
    function automatic int unsigned cpp_f(input int unsigned num_k, input int unsigned num_pe);
        return num_k / num_pe;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Purpose: raster-order (x,y) position counter for a square image.
// Ports:
//   clk, res_n : clock, synchronous active-low reset
//   step       : advance one pixel position
//   x, y       : current column / row
//   wrap       : one-cycle pulse the cycle after the last position (W-1,W-1) is stepped
module raster_counter #(
    parameter  int unsigned ImageWidth = 8,
    localparam int unsigned XW         = $clog2(ImageWidth)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic          wrap
);

    localparam logic [XW-1:0] LastPos = XW'(ImageWidth - 1);

    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic          r_wrap;

    // Position state; wrap is a single-cycle flag cleared every non-wrapping cycle.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (step) begin
                if (r_x == LastPos) begin
                    r_x <= '0;
                    if (r_y == LastPos) begin
                        r_y    <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_y <= r_y + XW'(1);
                    end
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign wrap = r_wrap;

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Purpose: time-multiplexes NumberOfK conv kernels onto ProcessingElements shared PEs.
//   Each accepted pixel is held for CPP cycles while pe_group steps 0..CPP-1.
// Ports:
//   clk, res_n          : clock, synchronous active-low reset
//   in_valid, in_data   : upstream pixel stream
//   out_ready           : pixel accepted this cycle when in_valid (combinational)
//   pe_stall            : PE array back-pressure, freezes the group sequence
//   pe_valid, pe_data,
//   pe_group            : held pixel and active kernel group for the PE array
//   out_valid           : per-kernel valid mask derived from pe_group/pe_valid
//   pixel_x, pixel_y    : raster position of the held pixel
//   frame_done          : one-cycle pulse after the final group of the last pixel
module conv_kernel_scheduler
    import cnn_pkg::*;
#(
    parameter  int unsigned BitSize            = 4,
    parameter  int unsigned ImageWidth         = 8,
    parameter  int unsigned NumberOfK          = 8,
    parameter  int unsigned ProcessingElements = 2,
    localparam int unsigned CPP                = cpp_f(NumberOfK, ProcessingElements),
    localparam int unsigned GW                 = (CPP > 1) ? $clog2(CPP) : 1,
    localparam int unsigned XW                 = $clog2(ImageWidth)
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 in_valid,
    input  logic [BitSize-1:0]   in_data,
    output logic                 out_ready,
    input  logic                 pe_stall,
    output logic                 pe_valid,
    output logic [BitSize-1:0]   pe_data,
    output logic [GW-1:0]        pe_group,
    output logic [NumberOfK-1:0] out_valid,
    output logic [XW-1:0]        pixel_x,
    output logic [XW-1:0]        pixel_y,
    output logic                 frame_done
);

    localparam int unsigned    PE        = ProcessingElements;
    localparam logic [GW-1:0]  LastGroup = GW'(CPP - 1);

    if ((NumberOfK % ProcessingElements) != 0) begin : g_bad_cfg
        $error("conv_kernel_scheduler: NumberOfK must be a multiple of ProcessingElements");
    end

    sched_state_t        r_state;
    logic [BitSize-1:0]  r_data;
    logic [GW-1:0]       r_group;
    logic                r_valid;

    sched_state_t        w_state_nxt;
    logic [BitSize-1:0]  w_data_nxt;
    logic [GW-1:0]       w_group_nxt;
    logic                w_valid_nxt;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;
    logic [NumberOfK-1:0] w_out_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= SCH_IDLE;
            r_data  <= '0;
            r_group <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_group <= w_group_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state, handshake and per-kernel valid decode.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_group_nxt = r_group;
        w_valid_nxt = r_valid;
        w_out_valid = '0;

        // A stall on the final group means the PEs have not consumed it yet.
        w_last   = (r_state == SCH_ISSUE) && (r_group == LastGroup) && !pe_stall;
        w_ready  = (r_state == SCH_IDLE) || w_last;
        w_accept = in_valid && w_ready;

        case (r_state)
            SCH_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SCH_ISSUE;
                    w_data_nxt  = in_data;
                    w_group_nxt = '0;
                    w_valid_nxt = 1'b1;
                end
            end
            SCH_ISSUE: begin
                if (pe_stall) begin
                    w_state_nxt = SCH_ISSUE;
                end else if (!w_last) begin
                    w_group_nxt = r_group + GW'(1);
                end else if (w_accept) begin
                    // Back-to-back pixel: restart the group sequence with no bubble.
                    w_data_nxt  = in_data;
                    w_group_nxt = '0;
                end else begin
                    w_state_nxt = SCH_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = SCH_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        for (int unsigned g = 0; g < CPP; g++) begin
            if (r_group == GW'(g)) begin
                w_out_valid[g*PE +: PE] = {PE{r_valid}};
            end
        end
    end

    raster_counter #(
        .ImageWidth (ImageWidth)
    ) u_raster (
        .clk   (clk),
        .res_n (res_n),
        .step  (w_last),
        .x     (pixel_x),
        .y     (pixel_y),
        .wrap  (frame_done)
    );

    assign out_ready = w_ready;
    assign pe_valid  = r_valid;
    assign pe_data   = r_data;
    assign pe_group  = r_group;
    assign out_valid = w_out_valid;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
module tb_conv_kernel_scheduler;

    // Default build: CPP = 4
    logic       clk;
    logic       res_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       pe_stall;
    logic       pe_valid;
    logic [3:0] pe_data;
    logic [1:0] pe_group;
    logic [7:0] out_valid;
    logic [2:0] pixel_x;
    logic [2:0] pixel_y;
    logic       frame_done;

    // CPP = 1 build
    logic       res1_n;
    logic       in_valid1;
    logic [3:0] in_data1;
    logic       out_ready1;
    logic       pe_stall1;
    logic       pe_valid1;
    logic [3:0] pe_data1;
    logic [0:0] pe_group1;
    logic [3:0] out_valid1;
    logic [2:0] pixel_x1;
    logic [2:0] pixel_y1;
    logic       frame_done1;

    conv_kernel_scheduler #(
        .BitSize(4), .ImageWidth(8), .NumberOfK(8), .ProcessingElements(2)
    ) u_dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .pe_stall(pe_stall), .pe_valid(pe_valid),
        .pe_data(pe_data), .pe_group(pe_group), .out_valid(out_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_done(frame_done)
    );

    conv_kernel_scheduler #(
        .BitSize(4), .ImageWidth(8), .NumberOfK(4), .ProcessingElements(4)
    ) u_dut1 (
        .clk(clk), .res_n(res1_n), .in_valid(in_valid1), .in_data(in_data1),
        .out_ready(out_ready1), .pe_stall(pe_stall1), .pe_valid(pe_valid1),
        .pe_data(pe_data1), .pe_group(pe_group1), .out_valid(out_valid1),
        .pixel_x(pixel_x1), .pixel_y(pixel_y1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: one entry per expected issued group.
    typedef struct packed {
        logic [3:0] d;
        logic [1:0] g;
        logic [2:0] x;
        logic [2:0] y;
    } sb_t;

    sb_t q[$];
    int  pix     = 0;
    int  acc_cnt = 0;
    int  pv_cnt  = 0;
    int  fd_cnt  = 0;
    logic exp_fd = 1'b0;

    always @(negedge clk) begin
        if (!res_n) begin
            q.delete();
            pix    = 0;
            exp_fd = 1'b0;
        end else begin
            sb_t  e;
            logic exp_rdy;
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            exp_fd = 1'b0;
            if (frame_done) fd_cnt++;
            if (pe_valid) begin
                pv_cnt++;
                if (q.size() == 0) begin
                    check("sb_underflow", 32'(q.size()), 32'd1);
                end else begin
                    e = q[0];
                    exp_rdy = (e.g == 2'd3) && !pe_stall;
                    check("pe_data",   32'(pe_data),   32'(e.d));
                    check("pe_group",  32'(pe_group),  32'(e.g));
                    check("pixel_x",   32'(pixel_x),   32'(e.x));
                    check("pixel_y",   32'(pixel_y),   32'(e.y));
                    check("out_valid", 32'(out_valid), 32'h3 << (2 * int'(e.g)));
                    check("out_ready", 32'(out_ready), 32'(exp_rdy));
                    if (!pe_stall) begin
                        void'(q.pop_front());
                        if (e.g == 2'd3 && e.x == 3'd7 && e.y == 3'd7) exp_fd = 1'b1;
                    end
                end
            end else begin
                check("sb_pending", 32'(q.size()), 32'd0);
                check("idle_ready", 32'(out_ready), 32'd1);
                check("idle_out_valid", 32'(out_valid), 32'd0);
            end
            if (in_valid && out_ready) begin
                for (int g = 0; g < 4; g++) begin
                    q.push_back('{d: in_data, g: 2'(g), x: 3'(pix % 8), y: 3'((pix / 8) % 8)});
                end
                pix = (pix + 1) % 64;
                acc_cnt++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        res_n    = 1'b0;
        in_valid = 1'b0;
        pe_stall = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
    endtask

    task automatic send_pixels(input int n);
        int base;
        base = acc_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 2000 && acc_cnt < base + n; i++) begin
            in_data = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_count", 32'(acc_cnt), 32'(base + n));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && pe_valid; i++) begin
            @(posedge clk); #1;
        end
        check("wait_idle", 32'(pe_valid), 32'd0);
    endtask

    initial begin
        int pv_base;
        int fd_base;
        logic [3:0] held;
        logic       ev1;
        logic [3:0] ed1;
        logic       er1;

        res_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h5;
        pe_stall  = 1'b0;
        res1_n    = 1'b0;
        in_valid1 = 1'b0;
        in_data1  = 4'h0;
        pe_stall1 = 1'b0;

        // 1: reset held with in_valid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_pe_valid",  32'(pe_valid),  32'd0);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_out_ready", 32'(out_ready), 32'd1);
        check("t1_pixel_x",   32'(pixel_x),   32'd0);
        check("t1_pixel_y",   32'(pixel_y),   32'd0);
        @(posedge clk); #1;
        res_n    = 1'b1;
        in_valid = 1'b0;

        // 2: single pixel
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 4'b0111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check("t2_group",     32'(pe_group),  32'(g));
            check("t2_out_valid", 32'(out_valid), 32'h3 << (2 * g));
            check("t2_out_ready", 32'(out_ready), 32'(g == 3));
            check("t2_data",      32'(pe_data),   32'h7);
        end
        @(negedge clk);
        check("t2_pe_valid_end", 32'(pe_valid), 32'd0);
        check("t2_pixel_x",      32'(pixel_x),  32'd1);

        // 3: back-to-back full frame
        do_reset();
        pv_base = pv_cnt;
        fd_base = fd_cnt;
        send_pixels(64);
        wait_idle();
        repeat (2) @(posedge clk); #1;
        check("t3_pv_cycles", 32'(pv_cnt - pv_base), 32'd256);
        check("t3_fd_pulses", 32'(fd_cnt - fd_base), 32'd1);
        check("t3_pixel_x",   32'(pixel_x), 32'd0);
        check("t3_pixel_y",   32'(pixel_y), 32'd0);

        // 4: stall for 3 cycles at group 2
        pv_base = pv_cnt;
        send_pixels(1);
        for (int i = 0; i < 10 && !(pe_valid && pe_group == 2'd2); i++) begin
            @(posedge clk); #1;
        end
        check("t4_reach_g2", 32'(pe_group), 32'd2);
        held     = pe_data;
        pe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_group",     32'(pe_group),  32'd2);
            check("t4_out_valid", 32'(out_valid), 32'h30);
            check("t4_out_ready", 32'(out_ready), 32'd0);
            check("t4_data",      32'(pe_data),   32'(held));
            @(posedge clk); #1;
        end
        pe_stall = 1'b0;
        wait_idle();
        check("t4_pv_cycles", 32'(pv_cnt - pv_base), 32'd7);

        // 5: reset at group 1 of pixel (3,2)
        do_reset();
        send_pixels(20);
        for (int i = 0; i < 10 && !(pe_valid && pe_group == 2'd1); i++) begin
            @(posedge clk); #1;
        end
        check("t5_group", 32'(pe_group), 32'd1);
        check("t5_x",     32'(pixel_x),  32'd3);
        check("t5_y",     32'(pixel_y),  32'd2);
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        check("t5_rst_pe_valid", 32'(pe_valid), 32'd0);
        check("t5_rst_x",        32'(pixel_x),  32'd0);
        check("t5_rst_y",        32'(pixel_y),  32'd0);
        send_pixels(1);
        check("t5_new_valid", 32'(pe_valid), 32'd1);
        check("t5_new_group", 32'(pe_group), 32'd0);
        wait_idle();

        // 6: CPP = 1 build, continuous input with random stalls
        @(posedge clk); #1;
        res1_n    = 1'b1;
        in_valid1 = 1'b1;
        in_data1  = 4'($urandom);
        ev1 = 1'b0;
        ed1 = 4'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            er1 = !ev1 || !pe_stall1;
            check("t6_pe_valid",  32'(pe_valid1),  32'(ev1));
            check("t6_out_ready", 32'(out_ready1), 32'(er1));
            check("t6_out_valid", 32'(out_valid1), ev1 ? 32'hF : 32'h0);
            check("t6_group",     32'(pe_group1),  32'd0);
            if (ev1) check("t6_data", 32'(pe_data1), 32'(ed1));
            if (in_valid1 && er1) begin
                ev1 = 1'b1;
                ed1 = in_data1;
            end else if (ev1 && !pe_stall1) begin
                ev1 = 1'b0;
            end
            @(posedge clk); #1;
            pe_stall1 = ($urandom_range(0, 3) == 0);
            in_data1  = 4'($urandom);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
